vga_timing_decoder: RTL and testbench

- Receive end of the VGA timing interface: takes incoming active-low HSync/VSync from a VGA timing source on the pixel clock.
- Measures line length and lines per frame, and verifies them against the nominal 640x480@60 timing.
- Locks after consecutive good frames, then regenerates xpos/ypos and a data-enable.
- Sits in front of capture/overlay logic that needs pixel coordinates for an externally timed video stream.

---
 rtl/vga_timing_decoder_if.sv | 23 ++
 rtl/vga_timing_decoder.sv | 160 ++++++++++++++++
 tb/tb_vga_timing_decoder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_decoder_if.sv
// Sync inputs and recovered timing outputs of the VGA timing decoder.
interface vga_timing_decoder_if;
    logic       HSync;
    logic       VSync;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic       de;
    logic       locked;
    logic       frame_start;
    logic [9:0] line_len;
    logic [9:0] frame_lines;
    logic       err;

    modport master (
        output HSync, VSync,
        input  xpos, ypos, de, locked, frame_start, line_len, frame_lines, err
    );

    modport slave (
        input  HSync, VSync,
        output xpos, ypos, de, locked, frame_start, line_len, frame_lines, err
    );
endinterface

// File: rtl/vga_timing_decoder.sv
// Measures incoming HSync/VSync timing, locks after consecutive good frames and
// regenerates pixel coordinates plus a data-enable for an externally timed stream.
module vga_timing_decoder #(
    parameter logic [9:0]  HActive     = 10'd640,
    parameter logic [9:0]  HPulse      = 10'd96,
    parameter logic [9:0]  HBack       = 10'd48,
    parameter logic [9:0]  HWhole      = 10'd800,
    parameter logic [9:0]  VActive     = 10'd480,
    parameter logic [9:0]  VPulse      = 10'd2,
    parameter logic [9:0]  VBack       = 10'd33,
    parameter logic [9:0]  VWhole      = 10'd525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    vga_timing_decoder_if.slave vif
);
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    localparam logic [9:0] HStart  = HPulse + HBack;
    localparam logic [9:0] HEnd    = HStart + HActive;
    localparam logic [9:0] VStart  = VPulse + VBack;
    localparam logic [9:0] VEnd    = VStart + VActive;
    localparam logic [2:0] LockCnt = 3'(LOCK_FRAMES);

    state_t     state, state_n;
    logic [2:0] gcnt, gcnt_n;
    logic       err_n;

    logic       hs_q, hs_d, vs_q, vs_d;
    logic [9:0] hcnt, vcnt;
    logic       vpend, bad;
    logic [9:0] xpos_q, ypos_q, line_len_q, frame_lines_q;
    logic       de_q, frame_start_q, err_q;

    logic       hf, vf, boundary, hsat, vsat, line_bad, bad_all, frame_good, act;
    logic [9:0] hcnt_inc, vcnt_inc;

    assign hf         = hs_d & ~hs_q;
    assign vf         = vs_d & ~vs_q;
    assign boundary   = hf & (vpend | vf);
    assign hsat       = (hcnt == 10'd1023);
    assign vsat       = (vcnt == 10'd1023);
    assign hcnt_inc   = hcnt + 10'd1;
    assign vcnt_inc   = vcnt + 10'd1;
    assign line_bad   = (hcnt_inc != HWhole);
    // The judged frame includes the line closed by this very edge.
    assign bad_all    = bad | line_bad;
    assign frame_good = ~bad_all & (vcnt_inc == VWhole);
    assign act        = (state == LOCKED) &&
                        (hcnt >= HStart) && (hcnt < HEnd) &&
                        (vcnt >= VStart) && (vcnt < VEnd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_q          <= 1'b1;
            hs_d          <= 1'b1;
            vs_q          <= 1'b1;
            vs_d          <= 1'b1;
            hcnt          <= '0;
            vcnt          <= '0;
            vpend         <= 1'b0;
            bad           <= 1'b0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            frame_start_q <= 1'b0;
            xpos_q        <= '0;
            ypos_q        <= '0;
            de_q          <= 1'b0;
            err_q         <= 1'b0;
            state         <= SEARCH;
            gcnt          <= '0;
        end else begin
            hs_q <= vif.HSync;
            hs_d <= hs_q;
            vs_q <= vif.VSync;
            vs_d <= vs_q;

            if (hf) begin
                hcnt       <= '0;
                line_len_q <= hcnt_inc;
                bad        <= boundary ? 1'b0 : bad_all;
            end else if (!hsat) begin
                hcnt <= hcnt_inc;
            end

            if (boundary) begin
                vcnt          <= '0;
                frame_lines_q <= vcnt_inc;
            end else if (hf && !vsat) begin
                vcnt <= vcnt_inc;
            end

            if (boundary)
                vpend <= 1'b0;
            else if (vf)
                vpend <= 1'b1;

            frame_start_q <= boundary;
            err_q         <= err_n;
            state         <= state_n;
            gcnt          <= gcnt_n;

            de_q   <= act;
            xpos_q <= act ? hcnt - HStart : '0;
            ypos_q <= act ? vcnt - VStart : '0;
        end
    end

    always_comb begin
        state_n = state;
        gcnt_n  = gcnt;
        err_n   = 1'b0;
        case (state)
            SEARCH: begin
                if (boundary) begin
                    state_n = VERIFY;
                    gcnt_n  = '0;
                end
            end
            VERIFY: begin
                if (boundary) begin
                    if (frame_good) begin
                        gcnt_n = gcnt + 3'd1;
                        if (gcnt + 3'd1 == LockCnt)
                            state_n = LOCKED;
                    end else begin
                        gcnt_n = '0;
                    end
                end
            end
            LOCKED: begin
                if ((hf && line_bad) || (boundary && (vcnt_inc != VWhole))) begin
                    err_n   = 1'b1;
                    state_n = SEARCH;
                    gcnt_n  = '0;
                end
            end
            default: begin
                state_n = SEARCH;
                gcnt_n  = '0;
            end
        endcase
        // A saturated counter means the stream is gone; it overrides any boundary.
        if (hsat || vsat) begin
            err_n   = (state == LOCKED);
            state_n = SEARCH;
            gcnt_n  = '0;
        end
    end

    assign vif.xpos        = xpos_q;
    assign vif.ypos        = ypos_q;
    assign vif.de          = de_q;
    assign vif.locked      = (state == LOCKED);
    assign vif.frame_start = frame_start_q;
    assign vif.line_len    = line_len_q;
    assign vif.frame_lines = frame_lines_q;
    assign vif.err         = err_q;
endmodule

// File: tb/tb_vga_timing_decoder.sv
// Scoreboard bench for vga_timing_decoder using a reduced 16x12 timing so whole
// frames (and lock sequences) fit in a short run.
module tb_vga_timing_decoder;
    localparam int HP = 3, HB = 2, HA = 8, HW = 16;
    localparam int VP = 2, VB = 2, VA = 5, VW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vga_timing_decoder_if vif();

    vga_timing_decoder #(
        .HActive(10'd8), .HPulse(10'd3), .HBack(10'd2), .HWhole(10'd16),
        .VActive(10'd5), .VPulse(10'd2), .VBack(10'd2), .VWhole(10'd12),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vif(vif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    int lock_rise = 0;

    logic [19:0] pix_q[$];
    int          fl_q[$];
    int          ll_q[$];

    // generator-side view of the stream it is producing
    bit vs_prev = 1'b1, vs_pend = 1'b0, skip = 1'b1, show_cur = 1'b0;
    int lines_since = 0, lrel = 0, last_len = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_xpos"}, int'(vif.xpos), 0);
        check({tag, "_ypos"}, int'(vif.ypos), 0);
        check({tag, "_de"}, int'(vif.de), 0);
        check({tag, "_locked"}, int'(vif.locked), 0);
        check({tag, "_frame_start"}, int'(vif.frame_start), 0);
        check({tag, "_line_len"}, int'(vif.line_len), 0);
        check({tag, "_frame_lines"}, int'(vif.frame_lines), 0);
        check({tag, "_err"}, int'(vif.err), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vif.HSync = 1'b1;
        vif.VSync = 1'b1;
        @(negedge clk);
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        vs_prev = 1'b1; vs_pend = 1'b0; skip = 1'b1; show_cur = 1'b0;
        lines_since = 0; lrel = 0;
    endtask

    // One call drives nlines lines; VSync falls at column vs_off of line 0 and
    // stays low for VP lines. Pixels of frames started while show=1 are expected.
    task automatic run_frame(input int nlines, input int stretch, input int vs_off,
                             input bit show, input int rst_line);
        bit rst_chk = 1'b0;
        for (int l = 0; l < nlines; l++) begin
            int len = (l == stretch) ? HW + 1 : HW;
            for (int p = 0; p < len; p++) begin
                bit hs, vs;
                hs = (p >= HP);
                vs = !((l > 0 || p >= vs_off) && (l < VP || (l == VP && p < vs_off)));
                @(negedge clk);
                if (rst_chk) begin
                    check_zero("midrst");
                    rst_chk = 1'b0;
                end
                if (l == rst_line && p == 0) begin
                    rst_n = 1'b0;
                    rst_chk = 1'b1;
                    skip = 1'b1;
                end else begin
                    rst_n = 1'b1;
                end
                if (vs_prev && !vs) vs_pend = 1'b1;
                vs_prev = vs;
                if (p == 0) begin
                    if (vs_pend) begin
                        fl_q.push_back(skip ? -1 : lines_since);
                        ll_q.push_back(skip ? -1 : last_len);
                        skip = 1'b0;
                        vs_pend = 1'b0;
                        lines_since = 1;
                        lrel = 0;
                        show_cur = show;
                    end else begin
                        lines_since++;
                        lrel++;
                    end
                end
                if (show_cur && lrel >= VP + VB && lrel < VP + VB + VA &&
                    p >= HP + HB && p < HP + HB + HA)
                    pix_q.push_back({10'(p - HP - HB), 10'(lrel - VP - VB)});
                vif.HSync = hs;
                vif.VSync = vs;
            end
            last_len = len;
        end
    endtask

    task automatic hold_high(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vif.HSync = 1'b1;
            vif.VSync = 1'b1;
        end
        vs_prev = 1'b1;
        skip = 1'b1;
        show_cur = 1'b0;
    endtask

    initial begin : monitor
        logic [19:0] e;
        int          efl, ell;
        logic        err_prev = 1'b0;
        logic        lock_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (vif.de) begin
                if (pix_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL de_unexpected: got de=1 x=%0d y=%0d want de=0",
                             vif.xpos, vif.ypos);
                end else begin
                    e = pix_q.pop_front();
                    check("xpos", int'(vif.xpos), int'(e[19:10]));
                    check("ypos", int'(vif.ypos), int'(e[9:0]));
                end
            end
            if (vif.frame_start) begin
                if (fl_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL frame_start_unexpected: got pulse want none");
                end else begin
                    efl = fl_q.pop_front();
                    ell = ll_q.pop_front();
                    if (efl >= 0) check("frame_lines", int'(vif.frame_lines), efl);
                    if (ell >= 0) check("line_len", int'(vif.line_len), ell);
                end
            end
            if (vif.err) begin
                err_cnt++;
                check("err_locked_low", int'(vif.locked), 0);
                check("err_width", int'(err_prev), 0);
            end
            if (vif.locked && !lock_prev) lock_rise++;
            err_prev = vif.err;
            lock_prev = vif.locked;
        end
    end

    initial begin : stimulus
        int e0, r0;
        vif.HSync = 1'b1;
        vif.VSync = 1'b1;
        do_reset();

        // frames one line short: never lock, never flag
        e0 = err_cnt; r0 = lock_rise;
        repeat (4) run_frame(VW - 1, -1, 0, 1'b0, -1);
        check("short_locked", int'(vif.locked), 0);
        check("short_lock_rise", lock_rise - r0, 0);
        check("short_err", err_cnt - e0, 0);

        // nominal stream after reset: lock at the third boundary
        do_reset();
        e0 = err_cnt;
        run_frame(VW, -1, 0, 1'b0, -1);
        run_frame(VW, -1, 0, 1'b0, -1);
        check("nom_prelock", int'(vif.locked), 0);
        run_frame(VW, -1, 0, 1'b1, -1);
        run_frame(VW, -1, 0, 1'b1, -1);
        check("nom_locked", int'(vif.locked), 1);
        check("nom_err", err_cnt - e0, 0);

        // one stretched line after the active area
        e0 = err_cnt;
        run_frame(VW, VW - 2, 0, 1'b1, -1);
        check("stretch_err", err_cnt - e0, 1);
        check("stretch_unlocked", int'(vif.locked), 0);
        run_frame(VW, -1, 0, 1'b0, -1);
        run_frame(VW, -1, 0, 1'b0, -1);
        check("stretch_prelock", int'(vif.locked), 0);
        run_frame(VW, -1, 0, 1'b1, -1);
        check("stretch_relock", int'(vif.locked), 1);
        check("stretch_err_total", err_cnt - e0, 1);

        // HSync stuck high until hcnt saturates
        e0 = err_cnt;
        hold_high(1100);
        check("stuck_err", err_cnt - e0, 1);
        check("stuck_unlocked", int'(vif.locked), 0);
        check("stuck_de", int'(vif.de), 0);
        run_frame(VW, -1, 0, 1'b0, -1);
        run_frame(VW, -1, 0, 1'b0, -1);
        run_frame(VW, -1, 0, 1'b0, -1);
        check("stuck_prelock", int'(vif.locked), 0);
        run_frame(VW, -1, 0, 1'b1, -1);
        check("stuck_relock", int'(vif.locked), 1);

        // one-cycle reset in the middle of a locked frame
        e0 = err_cnt;
        run_frame(VW, -1, 0, 1'b0, 2);
        check("midrst_unlocked", int'(vif.locked), 0);
        run_frame(VW, -1, 0, 1'b0, -1);
        run_frame(VW, -1, 0, 1'b0, -1);
        check("midrst_prelock", int'(vif.locked), 0);
        run_frame(VW, -1, 0, 1'b1, -1);
        check("midrst_relock", int'(vif.locked), 1);
        check("midrst_err", err_cnt - e0, 0);

        // VSync falling mid-line: boundary deferred to the next HSync edge
        do_reset();
        e0 = err_cnt;
        run_frame(VW, -1, 7, 1'b0, -1);
        run_frame(VW, -1, 7, 1'b0, -1);
        check("midvs_prelock", int'(vif.locked), 0);
        run_frame(VW, -1, 7, 1'b1, -1);
        check("midvs_locked", int'(vif.locked), 1);
        run_frame(VW, -1, 7, 1'b1, -1);
        check("midvs_stay_locked", int'(vif.locked), 1);
        check("midvs_err", err_cnt - e0, 0);

        repeat (5) @(negedge clk);
        check("pix_q_drained", pix_q.size(), 0);
        check("frame_q_drained", fl_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
